capture_unit: RTL and testbench
===============================

# capture_unit

Capture side of the CAN timing playback path: samples the bus once per `sampleClk` rising edge and packs 16 consecutive samples into one `dataTypes_pkg::mem_t` word. Each finished word is written into the record FIFO, in the same slot order that `playbackUnit` replays. The block stops after `requestNum` words have been written. The FIFO contents can be fed directly back into playback.

## Interface
Parameters:
- `SAMPLES_PER_WORD`, 16: samples per `mem_t` word; fixed by `mem_t`, not overridable.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `enable`  in  1  start request; sampled only in `s_arm`.
- `requestNum`  in  16  number of words to capture; sampled when leaving `s_arm`.
- `sampleClk`  in  1  bus bit-sample strobe (level); rising edge defines a sample.
- `dIn`  in  1  bus data value.
- `dValid`  in  1  bus actively driven; stored as the `enable` field of `output_t`.
- `fifoFull`  in  1  record FIFO full.
- `wrEn`  out  1  one-cycle FIFO write strobe.
- `wrData`  out  `mem_t`  assembled word; valid while `wrEn`=1.
- `capturing`  out  1  high in `s_cap` and `s_write`.
- `overflow`  out  1  sticky: a word was dropped because the FIFO was full.
- `complete`  out  1  high in `s_done`.

## Operation
- Edge detect:
  - `sampleClk_q` is a registered copy of `sampleClk`.
  - `tick = sampleClk & ~sampleClk_q` (combinational), so `tick` is high in the first clk cycle in which `sampleClk` is seen high.
- State machine: `s_idle`, `s_arm`, `s_cap`, `s_write`, `s_done`.
  - `s_idle`: unconditionally goes to `s_arm` on the next cycle after reset release.
  - `s_arm`: waits for `enable`=1. On that cycle, latch `requestNum` into `reqLatched` and clear `wordCount` and `idx`. If `requestNum`==0, go to `s_done`; otherwise go to `s_cap`.
  - `s_cap`: on each `tick`, write `{enable:dValid, out:dIn}` into `buf.outputData[idx]`. If `idx`==15, go to `s_write`; otherwise increment `idx`. Ticks outside `s_cap` are ignored.
  - `s_write` (one cycle):
    - If `fifoFull`=0: `wrEn`=1, `wrData`=`buf`, and `wordCount` increments.
    - If `fifoFull`=1: `wrEn`=0, `overflow` is set, the word is discarded and `wordCount` is unchanged.
    - Next state: `s_done` if the post-update `wordCount` ≥ `reqLatched`; otherwise `s_cap` with `idx`=0.
  - `s_done`: terminal; only `reset` leaves it.
- Sample k of a word lands in `outputData[k]`; slot 0 is the first sample captured.
- `enable` deasserting after `s_arm` has no effect.
- `requestNum` changing after it is latched has no effect.
- `wordCount` is 16 bits, unsigned. The comparison is unsigned. The counter cannot wrap because it stops at `reqLatched` ≤ 65535.
- Dropped words do not count toward `reqLatched`; capture continues until that many words have actually been written.

## Timing
- Reset: `wrEn`=0, `wrData`=0, `capturing`=0, `overflow`=0, `complete`=0. `idx`, `wordCount`, `sampleClk_q` and `buf` are cleared. State is `s_idle`.
- Reset mid-capture discards any partial word; no write is issued.
- Latency: the 16th `tick` occurs in cycle N; `wrEn` is asserted in cycle N+1.
- A new `tick` needs `sampleClk` low then high again, so the earliest next tick is N+2. The write cycle therefore never collides with a sample, and no sample is lost at the word boundary.
- `wrData` is a register and is stable in the `wrEn` cycle. It is don't-care otherwise.
- `fifoFull` is evaluated only in the `s_write` cycle. If it is high in that cycle, no write is issued.
- `complete` rises in the cycle after the final successful write.
- `sampleClk` held high produces one tick only.
- Edge detection runs in every state, so a `sampleClk` already high on entry to `s_cap` does not produce a tick.

## Structure
- `dataTypes_pkg` (existing): `output_t`, `mem_t`.
- `dataTypes_pkg` (add): `captureState_t` enum and `SAMPLES_PER_WORD`.
- Sub-module `capture_edge_detect`: rising-edge detector with synchronous active-high reset and a combinational `tick` output. It replaces `oneshot`, whose reset is active-low.
- FSM, sample buffer and counters live in `capture_unit`.

## Test plan
- Reset behaviour: assert `reset` for 3 cycles mid-word after 7 ticks → all outputs 0, no `wrEn`. After re-arm, the next word starts at `outputData[0]`.
- Single word: `requestNum`=1, FIFO never full, 16 ticks with `dIn`=1010…, `dValid`=1 → exactly one `wrEn`, one cycle after tick 16. `outputData[k].out` = k even ? 1 : 0, every `enable`=1. `complete`=1 on the next cycle.
- Multiple words: `requestNum`=3, 48 ticks spaced 4 cycles apart → three `wrEn` pulses. `complete` rises only after the third. Ticks after `complete` produce no writes.
- FIFO full: `requestNum`=2, `fifoFull`=1 during the first `s_write` → no `wrEn`, `overflow` goes to 1 and stays there. 32 further ticks → 2 writes, then `complete`.
- Zero request: `requestNum`=0 with `enable` pulsed → `s_done` in the next cycle, `complete`=1, and `wrEn` never asserted.
- Edge detection: `sampleClk` held high for 20 cycles → 1 sample. `sampleClk` toggling every cycle (2-cycle period) → 16 ticks in 31 cycles and one write. `dValid`=0 samples are stored with `enable`=0.

Source files
------------

// File: rtl/dataTypes_pkg.sv
// Shared types for the CAN timing capture/playback path: one sample slot,
// the 16-slot memory word and the capture FSM state encoding.
package dataTypes_pkg;

   // Samples per memory word; fixed by the layout of mem_t.
   localparam int SAMPLES_PER_WORD = 16;
   localparam int IDX_W            = $clog2(SAMPLES_PER_WORD);

   // One bus sample: whether the bus was driven, and the bit seen on it.
   typedef struct packed {
      logic enable;
      logic out;
   } output_t;

   // One FIFO word; outputData[0] is the oldest sample, as replayed by playback.
   typedef struct packed {
      output_t [SAMPLES_PER_WORD-1:0] outputData;
   } mem_t;

   typedef enum logic [2:0] {
      s_idle,
      s_arm,
      s_cap,
      s_write,
      s_done
   } captureState_t;

endpackage

// File: rtl/capture_unit_if.sv
// Control, bus-sample and record-FIFO signals of the capture unit. The
// slave side is the capture unit; the master side drives it.
interface capture_unit_if;
   import dataTypes_pkg::*;

   logic        enable;
   logic [15:0] requestNum;
   logic        sampleClk;
   logic        dIn;
   logic        dValid;
   logic        fifoFull;
   logic        wrEn;
   mem_t        wrData;
   logic        capturing;
   logic        overflow;
   logic        complete;

   modport slave (
      input  enable, requestNum, sampleClk, dIn, dValid, fifoFull,
      output wrEn, wrData, capturing, overflow, complete
   );

   modport master (
      output enable, requestNum, sampleClk, dIn, dValid, fifoFull,
      input  wrEn, wrData, capturing, overflow, complete
   );

endinterface

// File: rtl/capture_edge_detect.sv
// Rising-edge detector: tick_o is high in the first clk cycle in which
// level_i is seen high. A level held high yields exactly one tick.
module capture_edge_detect (
   input  logic clk,
   input  logic reset,
   input  logic level_i,
   output logic tick_o
);

   logic level_q;

   // Remember the previous cycle's level so a rise shows as high-now/low-before.
   always_ff @(posedge clk) begin
      if (reset) begin
         level_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignment keeps every flop sampling pre-edge values.
         level_q <= level_i;
      end
   end

   assign tick_o = level_i & ~level_q;

endmodule

// File: rtl/capture_unit.sv
// Capture side of the CAN timing playback path: packs 16 bus samples per
// word, writes each finished word to the record FIFO and stops after the
// requested number of words has actually been written.
module capture_unit
   import dataTypes_pkg::*;
(
   input  logic           clk,
   input  logic           reset,
   capture_unit_if.slave  bus
);

   captureState_t    state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [15:0]      wordCount_q, wordCount_d;
   logic [15:0]      reqLatched_q, reqLatched_d;
   mem_t             sampleBuf_q, sampleBuf_d;
   logic             overflow_q, overflow_d;
   logic             tick;

   capture_edge_detect u_edge (
      .clk     (clk),
      .reset   (reset),
      .level_i (bus.sampleClk),
      .tick_o  (tick)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= s_idle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; the write-cycle decision uses the post-update word count.
   always_comb begin
      // NOTE: default first so no path through the case leaves state_d unassigned (no latch).
      state_d = state_q;
      case (state_q)
         s_idle:  state_d = s_arm;
         s_arm:   if (bus.enable) state_d = (bus.requestNum == 16'd0) ? s_done : s_cap;
         s_cap:   if (tick && (idx_q == IDX_W'(SAMPLES_PER_WORD - 1))) state_d = s_write;
         s_write: state_d = (wordCount_d >= reqLatched_q) ? s_done : s_cap;
         s_done:  state_d = s_done;
         default: state_d = s_idle;
      endcase
   end

   // Datapath next values: request latch, sample slotting, word count, overflow.
   always_comb begin
      idx_d        = idx_q;
      wordCount_d  = wordCount_q;
      reqLatched_d = reqLatched_q;
      sampleBuf_d  = sampleBuf_q;
      overflow_d   = overflow_q;
      case (state_q)
         s_arm: begin
            if (bus.enable) begin
               reqLatched_d = bus.requestNum;
               wordCount_d  = '0;
               idx_d        = '0;
            end
         end
         s_cap: begin
            if (tick) begin
               sampleBuf_d.outputData[idx_q] = output_t'{enable: bus.dValid, out: bus.dIn};
               idx_d = idx_q + 1'b1;
            end
         end
         s_write: begin
            idx_d = '0;
            if (bus.fifoFull) begin
               overflow_d = 1'b1;
            end else begin
               wordCount_d = wordCount_q + 16'd1;
            end
         end
         default: ;
      endcase
   end

   // Datapath registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         idx_q        <= '0;
         wordCount_q  <= '0;
         reqLatched_q <= '0;
         // NOTE: the sample buffer is cleared on reset because it drives wrData directly.
         sampleBuf_q  <= '0;
         overflow_q   <= 1'b0;
      end else begin
         idx_q        <= idx_d;
         wordCount_q  <= wordCount_d;
         reqLatched_q <= reqLatched_d;
         sampleBuf_q  <= sampleBuf_d;
         overflow_q   <= overflow_d;
      end
   end

   // Outputs decoded from state; a full FIFO suppresses the write strobe.
   always_comb begin
      bus.wrEn      = (state_q == s_write) && !bus.fifoFull;
      bus.capturing = (state_q == s_cap) || (state_q == s_write);
      bus.complete  = (state_q == s_done);
   end

   assign bus.wrData   = sampleBuf_q;
   assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_capture_unit.sv
// Directed bench for capture_unit: reset, single/multi word capture, FIFO
// full drop, zero request and edge-detection corner cases.
module tb_capture_unit;
   import dataTypes_pkg::*;

   logic clk = 1'b0;
   logic reset;

   capture_unit_if bus ();

   capture_unit dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   int cyc      = 0;
   int errors   = 0;
   int checks   = 0;
   int wr_cyc   = -1;
   int done_cyc = -1;
   int tick_cyc = -1;
   logic [31:0] wr_q [$];

   always @(posedge clk) cyc++;

   // Record every FIFO write and the first cycle complete is seen.
   always @(negedge clk) begin
      logic [31:0] w;
      if (bus.wrEn === 1'b1) begin
         w = bus.wrData;
         wr_q.push_back(w);
         wr_cyc = cyc;
      end
      if (bus.complete === 1'b1 && done_cyc < 0) done_cyc = cyc;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Hold reset for 3 cycles; returns with reset still asserted.
   task automatic reset_hold();
      reset          = 1'b1;
      bus.enable     = 1'b0;
      bus.requestNum = 16'd0;
      bus.sampleClk  = 1'b0;
      bus.dIn        = 1'b0;
      bus.dValid     = 1'b0;
      bus.fifoFull   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      wr_q.delete();
      wr_cyc   = -1;
      done_cyc = -1;
   endtask

   // Release reset; returns in the first s_arm cycle.
   task automatic release_reset();
      reset = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic arm(input logic [15:0] n);
      bus.requestNum = n;
      bus.enable     = 1'b1;
      @(posedge clk);
      #1;
      bus.enable = 1'b0;
   endtask

   task automatic do_tick(input logic d, input logic v, input int hi, input int lo);
      tick_cyc      = cyc;
      bus.sampleClk = 1'b1;
      bus.dIn       = d;
      bus.dValid    = v;
      repeat (hi) @(posedge clk);
      #1;
      bus.sampleClk = 1'b0;
      repeat (lo) @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset state
      reset_hold();
      check("rst_wrEn",      bus.wrEn,      1'b0);
      check("rst_wrData",    bus.wrData,    32'h0);
      check("rst_capturing", bus.capturing, 1'b0);
      check("rst_overflow",  bus.overflow,  1'b0);
      check("rst_complete",  bus.complete,  1'b0);

      // Reset mid-word after 7 ticks
      release_reset();
      arm(16'd1);
      check("arm_capturing", bus.capturing, 1'b1);
      for (int k = 0; k < 7; k++) do_tick(1'b1, 1'b1, 2, 2);
      reset_hold();
      check("midrst_wrEn",      bus.wrEn,      1'b0);
      check("midrst_wrData",    bus.wrData,    32'h0);
      check("midrst_capturing", bus.capturing, 1'b0);
      check("midrst_complete",  bus.complete,  1'b0);

      // Single word, pattern 1010..., requestNum changed after latch
      release_reset();
      check("midrst_no_write", wr_q.size(), 0);
      arm(16'd1);
      bus.requestNum = 16'd5;
      for (int k = 0; k < 16; k++) do_tick((k % 2) == 0, 1'b1, 2, 2);
      check("single_count",     wr_q.size(), 1);
      check("single_data",      wr_q[0],     32'hBBBB_BBBB);
      check("single_latency",   wr_cyc,      tick_cyc + 1);
      check("single_done_cyc",  done_cyc,    wr_cyc + 1);
      check("single_complete",  bus.complete,  1'b1);
      check("single_capturing", bus.capturing, 1'b0);

      // Three words; requestNum cleared after latch has no effect
      reset_hold();
      release_reset();
      arm(16'd3);
      bus.requestNum = 16'd0;
      for (int w = 0; w < 3; w++) begin
         for (int s = 0; s < 16; s++) do_tick(w != 0, w != 1, 2, 2);
         if (w == 1) begin
            check("multi_count2",     wr_q.size(),  2);
            check("multi_not_done",   bus.complete, 1'b0);
            check("multi_capturing2", bus.capturing, 1'b1);
         end
      end
      check("multi_count3",   wr_q.size(), 3);
      check("multi_word0",    wr_q[0],     32'hAAAA_AAAA);
      check("multi_word1",    wr_q[1],     32'h5555_5555);
      check("multi_word2",    wr_q[2],     32'hFFFF_FFFF);
      check("multi_latency",  wr_cyc,      tick_cyc + 1);
      check("multi_complete", bus.complete, 1'b1);
      for (int s = 0; s < 16; s++) do_tick(1'b1, 1'b1, 2, 2);
      check("multi_after_done", wr_q.size(), 3);

      // FIFO full during the first write cycle
      reset_hold();
      release_reset();
      arm(16'd2);
      bus.fifoFull = 1'b1;
      for (int s = 0; s < 16; s++) do_tick(1'b1, 1'b1, 2, 2);
      check("full_no_write",  wr_q.size(),   0);
      check("full_overflow",  bus.overflow,  1'b1);
      check("full_capturing", bus.capturing, 1'b1);
      bus.fifoFull = 1'b0;
      for (int s = 0; s < 32; s++) do_tick(1'b0, 1'b1, 2, 2);
      check("full_count",     wr_q.size(),  2);
      check("full_word0",     wr_q[0],      32'hAAAA_AAAA);
      check("full_word1",     wr_q[1],      32'hAAAA_AAAA);
      check("full_complete",  bus.complete, 1'b1);
      check("full_sticky",    bus.overflow, 1'b1);

      // Zero request
      reset_hold();
      release_reset();
      arm(16'd0);
      check("zero_complete",  bus.complete,  1'b1);
      check("zero_capturing", bus.capturing, 1'b0);
      for (int s = 0; s < 16; s++) do_tick(1'b1, 1'b1, 2, 2);
      check("zero_no_write", wr_q.size(), 0);

      // sampleClk already high on entry to s_cap, held 20 cycles: no sample
      reset_hold();
      release_reset();
      bus.sampleClk = 1'b1;
      bus.dIn       = 1'b0;
      bus.dValid    = 1'b0;
      arm(16'd1);
      repeat (19) @(posedge clk);
      #1;
      bus.sampleClk = 1'b0;
      @(posedge clk);
      #1;
      for (int s = 0; s < 16; s++) do_tick(1'b1, 1'b1, 1, 1);
      check("entry_high_count",   wr_q.size(), 1);
      check("entry_high_data",    wr_q[0],     32'hFFFF_FFFF);
      check("entry_high_latency", wr_cyc,      tick_cyc + 1);

      // sampleClk held high 20 cycles inside s_cap: one sample, then fast toggling
      reset_hold();
      release_reset();
      arm(16'd1);
      do_tick(1'b0, 1'b0, 20, 1);
      for (int s = 0; s < 15; s++) do_tick(1'b1, 1'b1, 1, 1);
      check("held_count",   wr_q.size(), 1);
      check("held_data",    wr_q[0],     32'hFFFF_FFFC);
      check("held_latency", wr_cyc,      tick_cyc + 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
